// File: rtl/mux41_rr_if.sv
// Handshake bundle for the 4:1 round-robin mux: four input streams plus one tagged output stream.
// slave is the mux's view; master is the view of whatever drives the inputs and sinks the output.
interface mux41_rr_if #(
  parameter int W = 8
);
  logic [3:0]     I_valid;
  logic [4*W-1:0] I_data;
  logic [3:0]     I_ready;
  logic           Y_valid;
  logic [W-1:0]   Y_data;
  logic [1:0]     S;
  logic           Y_ready;

  modport slave (
    input  I_valid, I_data, Y_ready,
    output I_ready, Y_valid, Y_data, S
  );

  modport master (
    output I_valid, I_data, Y_ready,
    input  I_ready, Y_valid, Y_data, S
  );
endinterface

// File: rtl/mux41_rr.sv
// Round-robin merge of four valid/ready channels into one registered output tagged with its source channel.
// Latency 1 cycle; back-to-back loads while Y_ready is high; all I_ready bits low while FULL and stalled.
module mux41_rr #(
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst,
  mux41_rr_if.slave bus
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_data;
  logic [1:0]   r_s;
  logic [1:0]   r_last;

  logic [W-1:0] w_ch [4];
  logic [1:0]   w_g;
  logic [1:0]   w_idx;
  logic         w_found;
  logic         w_any;
  logic         w_load_ok;
  logic         w_take;
  logic [3:0]   w_ready;

  // Search starts just past the last grant and wraps, so the last grantee is tried last.
  always_comb begin
    w_g     = r_last;
    w_idx   = r_last;
    w_found = 1'b0;
    w_any   = |bus.I_valid;
    for (int i = 1; i <= 4; i++) begin
      w_idx = r_last + 2'(i);
      if (!w_found && bus.I_valid[w_idx]) begin
        w_g     = w_idx;
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_ch[k] = bus.I_data[k*W +: W];
    end
  end

  // Gating with rst keeps I_ready low while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    w_load_ok   = (r_state == S_EMPTY) || bus.Y_ready;
    w_take      = w_load_ok && w_any && !rst;
    w_ready     = w_take ? 4'(4'b0001 << w_g) : 4'b0000;
    case (r_state)
      S_EMPTY: if (w_any)                 w_state_nxt = S_FULL;
      S_FULL:  if (bus.Y_ready && !w_any) w_state_nxt = S_EMPTY;
      default:                            w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_s    <= 2'd0;
      r_last <= 2'd3;
    end else if (w_take) begin
      r_data <= w_ch[w_g];
      r_s    <= w_g;
      r_last <= w_g;
    end
  end

  assign bus.I_ready = w_ready;
  assign bus.Y_valid = (r_state == S_FULL);
  assign bus.Y_data  = r_data;
  assign bus.S       = r_s;

endmodule

// File: tb/tb_mux41_rr.sv
// Directed bench for mux41_rr: reset, single channel, round robin, backpressure, skip/wrap and drain.
module tb_mux41_rr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  mux41_rr_if #(.W(8)) bus ();

  mux41_rr #(.W(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
    chk({tag, ".Y_valid"}, 32'(bus.Y_valid), 32'(v));
    chk({tag, ".Y_data"},  32'(bus.Y_data),  32'(d));
    chk({tag, ".S"},       32'(bus.S),       32'(s));
  endtask

  initial begin
    bus.I_valid = 4'hF;
    bus.I_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.Y_ready = 1'b1;
    #2;
    chk_out("rst0", 1'b0, 8'h00, 2'd0);
    chk("rst0.I_ready", 32'(bus.I_ready), 32'h0);

    // Round robin from reset: channel 0 first, then 1,2,3,0,1.
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rr.I_ready0", 32'(bus.I_ready), 32'h1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_out($sformatf("rr%0d", i), 1'b1, 8'(8'h10 + (i % 4)), 2'(i % 4));
    end

    // Backpressure while FULL holding S=1 / 0x11.
    bus.Y_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp%0d.I_ready", i), 32'(bus.I_ready), 32'h0);
      tick();
      chk_out($sformatf("bp%0d", i), 1'b1, 8'h11, 2'd1);
    end
    bus.Y_ready = 1'b1;
    #1;
    chk("bp.release.I_ready", 32'(bus.I_ready), 32'h4);
    tick();
    chk_out("bp.release", 1'b1, 8'h12, 2'd2);

    // Reset mid-stream while FULL clears the register immediately.
    rst = 1'b1;
    #1;
    chk_out("rst_mid", 1'b0, 8'h00, 2'd0);
    chk("rst_mid.I_ready", 32'(bus.I_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_rel.I_ready", 32'(bus.I_ready), 32'h1);
    tick();
    chk_out("rst_rel", 1'b1, 8'h10, 2'd0);

    // Single channel 2, then drain with nothing pending.
    bus.I_valid = 4'b0100;
    bus.I_data  = {8'h00, 8'hA5, 8'h00, 8'h00};
    #1;
    chk("single.I_ready", 32'(bus.I_ready), 32'h4);
    tick();
    chk_out("single", 1'b1, 8'hA5, 2'd2);
    bus.I_valid = 4'b0000;
    #1;
    chk("drain.I_ready", 32'(bus.I_ready), 32'h0);
    tick();
    chk_out("drain", 1'b0, 8'hA5, 2'd2);

    // Skip/wrap: last=2 with channels 1 and 3 pending.
    bus.I_valid = 4'b1010;
    bus.I_data  = {8'h23, 8'h00, 8'h21, 8'h00};
    #1;
    chk("skip.I_ready3", 32'(bus.I_ready), 32'h8);
    tick();
    chk_out("skip3", 1'b1, 8'h23, 2'd3);
    bus.I_valid = 4'b0010;
    #1;
    chk("skip.I_ready1", 32'(bus.I_ready), 32'h2);
    tick();
    chk_out("skip1", 1'b1, 8'h21, 2'd1);
    bus.I_valid = 4'b0001;
    bus.I_data  = {8'h00, 8'h00, 8'h00, 8'h30};
    #1;
    chk("wrap.I_ready0", 32'(bus.I_ready), 32'h1);
    tick();
    chk_out("wrap0", 1'b1, 8'h30, 2'd0);
    bus.I_valid = 4'b0000;
    tick();
    chk_out("wrap.drain", 1'b0, 8'h30, 2'd0);

    // EMPTY loads even with Y_ready low; then stalls with I_ready low.
    bus.Y_ready = 1'b0;
    bus.I_valid = 4'b0100;
    bus.I_data  = {8'h00, 8'h42, 8'h00, 8'h00};
    #1;
    chk("empty_load.I_ready", 32'(bus.I_ready), 32'h4);
    tick();
    chk_out("empty_load", 1'b1, 8'h42, 2'd2);
    bus.I_data = {8'h00, 8'h43, 8'h00, 8'h00};
    #1;
    chk("stall.I_ready", 32'(bus.I_ready), 32'h0);
    tick();
    chk_out("stall", 1'b1, 8'h42, 2'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux41_rr.md
# mux41_rr

Four-channel round-robin multiplexer: merges four independent valid/ready input streams onto one registered output stream, tagging each word with its source channel. It is the gathering end of the 1:4 demultiplexer path. Its `S`-style channel tag drives the select of a `demux14` downstream, so traffic can be split back out per channel.

## Interface

Parameters:

- `W`, default 8: data width of every channel and of the output.

Ports:

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `I_valid` input 4: per-channel word-available flags; bit k is channel k.
- `I_data` input 4*W: channel k data at bits [k*W+W-1 : k*W].
- `I_ready` output 4: per-channel accept strobe, one-hot or zero.
- `Y_valid` output 1: output register holds a word.
- `Y_data` output W: output word.
- `S` output 2: source channel of `Y_data`.
- `Y_ready` input 1: downstream accepts the current word.

## Operation

- **State.**
  - Output register: `Y_valid`, `Y_data`, `S`.
  - 2-bit last-grant pointer `last`.
  - Two conceptual states: EMPTY (`Y_valid`=0) and FULL (`Y_valid`=1).
- **Load opportunity.** `load_ok = !Y_valid || Y_ready`. The register is either empty or draining this cycle.
- **Arbitration.**
  - Evaluated combinationally every cycle.
  - Search order is `last+1`, `last+2`, `last+3`, `last`, all mod 4, so the search wraps from 3 back to 0.
  - `g` is the first channel in that order with `I_valid[g]`=1.
  - `any` is 1 when some `I_valid` bit is 1.
- **Handshake.** `I_ready[g]` = `load_ok && any`; all other `I_ready` bits are 0. A transfer on channel k happens when `I_valid[k] && I_ready[k]`.
- **Transitions.**
  - EMPTY with `any`=1 → FULL: load `Y_data` ← channel g, `S` ← g, `last` ← g.
  - EMPTY with `any`=0 → stay EMPTY; the register is unchanged.
  - FULL with `Y_ready`=0 → stay FULL. `Y_data` and `S` hold; all `I_ready` bits are 0.
  - FULL with `Y_ready`=1 and `any`=1 → stay FULL. Load the new word from g in the same cycle (back-to-back); `last` ← g.
  - FULL with `Y_ready`=1 and `any`=0 → EMPTY. `Y_data` and `S` keep their stale values.
- **Pointer.** `last` changes only on a transfer.
- **Input rules.** Channels must hold `I_data`/`I_valid` until accepted. The block never drops or duplicates a word.

## Timing

- **Reset values** (while `rst`=1, asynchronously):
  - `Y_valid`=0, `Y_data`=0, `S`=0.
  - `last`=3, so channel 0 has top priority first.
  - `I_ready`=0 during reset.
- **Latency.** A word accepted at edge n appears on `Y_valid`/`Y_data`/`S` after edge n; it is visible in cycle n+1.
- **Throughput.** One word per cycle with `Y_ready` held high and inputs pending.
- **Combinational paths.** `I_ready` depends on `I_valid`, `Y_valid`, `Y_ready` and `last`. There is no path from `I_data` to any output.
- **Fairness.** With all four channels valid continuously, grants cycle 0,1,2,3,0,… Every requester is served within 4 transfers.
- **Reset mid-operation.** A held word is discarded, `last` returns to 3, and no transfer is recorded in the reset cycle.
- **Deassertion.** After `rst` falls, the first edge may load.

## Test plan

- **Reset:** assert `rst` mid-stream while FULL → `Y_valid`=0, `Y_data`=0, `S`=0 immediately, before any clock. After release, with all channels valid, the first grant is channel 0.
- **Single channel:** `I_valid`=4'b0100 with channel 2 data 0xA5, `Y_ready`=1 → `I_ready`=4'b0100 for one cycle. The next cycle shows `Y_valid`=1, `Y_data`=0xA5, `S`=2, then EMPTY.
- **Round robin:** all `I_valid`=1, data 0x10/0x11/0x12/0x13, `Y_ready`=1 → output `S` sequence 0,1,2,3,0,1 on consecutive cycles, `Y_valid` continuously 1.
- **Backpressure:** FULL with `S`=1 and `Y_data`=0x11, `Y_ready`=0 for 5 cycles, all channels valid → `Y_data`/`S` stable and `I_ready`=0 throughout. On `Y_ready`=1, channel 2 is loaded the same edge.
- **Skip/wrap:** `last`=2 with only channels 1 and 3 valid → channel 3 granted, then channel 1. Then `last`=1 with only channel 0 valid → channel 0.
- **Drain:** FULL, `Y_ready`=1, `I_valid`=0 → `Y_valid`=0 next cycle and `I_ready` stays 0.
